// File: rtl/request_encoder_if.sv
// Request/address handshake bundle for request_encoder.
// The master modport is the encoder side; the slave modport is the source/consumer side.
interface request_encoder_if #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned ADDR_W = 2
);
  logic              enable;
  logic [WIDTH-1:0]  req;
  logic [ADDR_W-1:0] addr;
  logic              valid;
  logic              ready;
  logic [WIDTH-1:0]  pending;
  logic              overflow;

  modport master (
    input  enable, req, ready,
    output addr, valid, pending, overflow
  );

  modport slave (
    output enable, req, ready,
    input  addr, valid, pending, overflow
  );
endinterface

// File: rtl/request_encoder.sv
// Sequential WIDTH-to-ADDR_W encoder: captures request pulses and presents them one per transfer.
// Define REQUEST_ENCODER_RR_EN for round-robin selection; otherwise the lowest pending index wins.
module request_encoder #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned ADDR_W = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  request_encoder_if.master    bus
);

  logic [WIDTH-1:0]  pend_q;
  logic [ADDR_W-1:0] addr_q;
  logic              valid_q;
  logic              ovf_q;

  logic              found;
  logic [ADDR_W-1:0] sel;
  logic              slot_free;
  logic              do_sel;
  logic [WIDTH-1:0]  sel_mask;
  logic [WIDTH-1:0]  cap;
  logic [WIDTH-1:0]  pend_left;

`ifdef REQUEST_ENCODER_RR_EN
  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W-1:0] idx;

  // Search starts at the pointer; ADDR_W-bit addition wraps since WIDTH == 2**ADDR_W.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int unsigned k = 0; k < WIDTH; k++) begin
      idx = ptr_q + ADDR_W'(k);
      if (!found && pend_q[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end
`else
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (!found && pend_q[i]) begin
        found = 1'b1;
        sel   = ADDR_W'(i);
      end
    end
  end
`endif

  // Capture is ORed in after the selected bit is cleared, so a same-edge re-request re-arms it.
  always_comb begin
    slot_free = !valid_q || bus.ready;
    do_sel    = slot_free && found;
    sel_mask  = do_sel ? (WIDTH'(1) << sel) : '0;
    cap       = bus.enable ? bus.req : '0;
    pend_left = pend_q & ~sel_mask;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q  <= '0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef REQUEST_ENCODER_RR_EN
      ptr_q   <= '0;
`endif
    end else begin
      pend_q <= pend_left | cap;
      if (|(cap & pend_left))
        ovf_q <= 1'b1;
      if (slot_free) begin
        valid_q <= found;
        if (found) begin
          addr_q <= sel;
`ifdef REQUEST_ENCODER_RR_EN
          ptr_q  <= sel + ADDR_W'(1);
`endif
        end
      end
    end
  end

  assign bus.addr     = addr_q;
  assign bus.valid    = valid_q;
  assign bus.pending  = pend_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_request_encoder.sv
// Self-checking bench for request_encoder: directed scenarios plus random traffic
// compared against a per-request reference model (fixed or round-robin selection).
module tb_request_encoder;

  logic clk;
  logic reset;

  request_encoder_if #(.WIDTH(4), .ADDR_W(2)) bus ();

  request_encoder #(.WIDTH(4), .ADDR_W(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: one flag per request line, plus the presented slot.
  bit m_pend[4];
  bit m_valid;
  int m_addr;
  bit m_ovf;
  int m_ptr;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int pack_pend();
    int v = 0;
    for (int i = 0; i < 4; i++)
      if (m_pend[i]) v += (1 << i);
    return v;
  endfunction

  // Advance one clock: predict from current inputs, clock the DUT, compare everything.
  task automatic step();
    bit np[4];
    bit nv;
    int na;
    int nptr;
    bit novf;
    int s;
    bit free;
    bit hit;
    int idx;
    np = m_pend; nv = m_valid; na = m_addr; nptr = m_ptr; novf = m_ovf; s = -1;
    if (reset) begin
      for (int i = 0; i < 4; i++) np[i] = 1'b0;
      nv = 1'b0; na = 0; nptr = 0; novf = 1'b0;
    end else begin
      free = !m_valid || bus.ready;
      if (free) begin
        for (int k = 0; k < 4; k++) begin
`ifdef REQUEST_ENCODER_RR_EN
          idx = (m_ptr + k) % 4;
`else
          idx = k;
`endif
          if (s < 0 && m_pend[idx]) s = idx;
        end
      end
      for (int i = 0; i < 4; i++) begin
        hit = bus.enable && bus.req[i];
        if (hit && m_pend[i] && i != s) novf = 1'b1;
        np[i] = (m_pend[i] && i != s) || hit;
      end
      if (free) begin
        if (s >= 0) begin
          nv = 1'b1; na = s; nptr = (s + 1) % 4;
        end else begin
          nv = 1'b0;
        end
      end
    end
    @(posedge clk);
    #1;
    m_pend = np; m_valid = nv; m_addr = na; m_ptr = nptr; m_ovf = novf;
    check("valid",    int'(bus.valid),    int'(m_valid));
    check("addr",     int'(bus.addr),     m_addr);
    check("pending",  int'(bus.pending),  pack_pend());
    check("overflow", int'(bus.overflow), int'(m_ovf));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.enable = 1'b1;
    bus.req    = '0;
    bus.ready  = 1'b1;
    for (int i = 0; i < 4; i++) m_pend[i] = 1'b0;
    m_valid = 1'b0; m_addr = 0; m_ovf = 1'b0; m_ptr = 0;

    // Idle after reset
    step();
    do_reset();
    for (int c = 0; c < 10; c++) begin
      step();
      check("idle_valid", int'(bus.valid), 0);
      check("idle_pending", int'(bus.pending), 0);
    end

    // Single request on line 2
    bus.req = 4'b0100;
    step();
    check("single_pend", int'(bus.pending), 4);
    check("single_valid0", int'(bus.valid), 0);
    bus.req = '0;
    step();
    check("single_valid", int'(bus.valid), 1);
    check("single_addr", int'(bus.addr), 2);
    check("single_drained", int'(bus.pending), 0);
    step();
    check("single_done", int'(bus.valid), 0);

    // Capture disabled
    bus.enable = 1'b0;
    bus.req    = 4'b1111;
    for (int c = 0; c < 3; c++) begin
      step();
      check("dis_pending", int'(bus.pending), 0);
      check("dis_valid", int'(bus.valid), 0);
    end
    bus.enable = 1'b1;
    bus.req    = '0;

    // Multi-hot burst with back-pressure, then a repeat after pointer wrap
    do_reset();
    bus.ready = 1'b0;
    bus.req   = 4'b1011;
    step();
    check("burst_pend", int'(bus.pending), 11);
    bus.req = '0;
    step();
    check("burst_first", int'(bus.addr), 0);
    for (int c = 0; c < 3; c++) begin
      step();
      check("burst_hold_addr", int'(bus.addr), 0);
      check("burst_hold_valid", int'(bus.valid), 1);
    end
    bus.ready = 1'b1;
    step();
    check("burst_second", int'(bus.addr), 1);
    step();
    check("burst_third", int'(bus.addr), 3);
    check("burst_third_v", int'(bus.valid), 1);
    step();
    check("burst_end", int'(bus.valid), 0);
    bus.req = 4'b0011;
    step();
    bus.req = '0;
    step();
    check("again_first", int'(bus.addr), 0);
    step();
    check("again_second", int'(bus.addr), 1);
    step();

    // Overflow: same line twice while the slot is full
    do_reset();
    bus.ready = 1'b0;
    bus.req   = 4'b0001;
    step();
    bus.req = '0;
    step();
    bus.req = 4'b0010;
    step();
    check("ovf_pre", int'(bus.overflow), 0);
    step();
    check("ovf_set", int'(bus.overflow), 1);
    bus.req = '0;
    for (int c = 0; c < 3; c++) begin
      step();
      check("ovf_sticky", int'(bus.overflow), 1);
    end
    do_reset();
    check("ovf_cleared", int'(bus.overflow), 0);

    // Re-request on the edge the line is selected: re-arms, no overflow
    bus.ready = 1'b1;
    bus.req   = 4'b0010;
    step();
    step();
    check("rearm_ovf", int'(bus.overflow), 0);
    check("rearm_pend", int'(bus.pending), 2);
    check("rearm_addr", int'(bus.addr), 1);
    bus.req = '0;
    step();
    check("rearm_second_v", int'(bus.valid), 1);
    step();

    // Reset while presenting with lines still pending
    do_reset();
    bus.ready = 1'b0;
    bus.req   = 4'b1110;
    step();
    bus.req = '0;
    step();
    check("pre_rst_pend", int'(bus.pending), 12);
    check("pre_rst_valid", int'(bus.valid), 1);
    reset     = 1'b1;
    bus.req   = 4'b1111;
    bus.ready = 1'b1;
    step();
    reset   = 1'b0;
    bus.req = '0;
    check("rst_valid", int'(bus.valid), 0);
    check("rst_pend", int'(bus.pending), 0);
    for (int c = 0; c < 5; c++) begin
      step();
      check("post_rst_valid", int'(bus.valid), 0);
    end

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      reset      = ($urandom_range(0, 39) == 0);
      bus.enable = ($urandom_range(0, 7) != 0);
      bus.ready  = $urandom_range(0, 1);
      bus.req    = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
